seq_shifter: RTL

- Multi-cycle iterative shifter: shifts 1 bit position per clock.
- Functionally equivalent to the combinational shifter block: same operand, amount, arith and left controls.
- Sits behind a valid/ready request interface and a valid/ready response interface.
- Used where area matters more than latency, and as a cross-check engine against the combinational shifter.

---
 rtl/seq_shifter_if.sv | 29 ++
 rtl/seq_shifter.sv | 84 ++++++++
 2 files changed

// File: rtl/seq_shifter_if.sv
// Request/response bundle for the iterative shifter.
// Signal names follow the shifter's point of view: _i flows into the shifter, _o flows out.
interface seq_shifter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [WIDTH-1:0]   shift_in_i;
    logic [SHAMT_W-1:0] shift_amount_i;
    logic               arith_shift_i;
    logic               left_shift_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [WIDTH-1:0]   shift_out_o;
    logic               busy_o;

    // Requester/consumer side
    modport master (
        output in_valid_i, shift_in_i, shift_amount_i, arith_shift_i, left_shift_i, out_ready_i,
        input  in_ready_o, out_valid_o, shift_out_o, busy_o
    );

    // Shifter side
    modport slave (
        input  in_valid_i, shift_in_i, shift_amount_i, arith_shift_i, left_shift_i, out_ready_i,
        output in_ready_o, out_valid_o, shift_out_o, busy_o
    );
endinterface

// File: rtl/seq_shifter.sv
// Iterative shifter: moves the operand one bit position per clock, then holds the
// result until the consumer accepts it. WIDTH must match the connected interface.
module seq_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    seq_shifter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               arith_q, arith_d;
    logic               left_q, left_d;

    // State, data, remaining count and latched controls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
            arith_q <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            arith_q <= arith_d;
            left_q  <= left_d;
        end
    end

    // Next-state: load on accept, one bit per cycle while count != 0, hold in DONE
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        arith_d = arith_q;
        left_d  = left_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    data_d  = bus.shift_in_i;
                    count_d = bus.shift_amount_i;
                    arith_d = bus.arith_shift_i;
                    left_d  = bus.left_shift_i;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (count_q != '0) begin
                    count_d = count_q - SHAMT_W'(1);
                    if (left_q) begin
                        data_d = {data_q[WIDTH-2:0], 1'b0};
                    end else begin
                        // Arithmetic right replicates the MSB, logical right fills zero
                        data_d = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        bus.in_ready_o  = (state_q == StIdle);
        bus.out_valid_o = (state_q == StDone);
        bus.busy_o      = (state_q != StIdle);
        bus.shift_out_o = data_q;
    end

endmodule
